// File: rtl/serialize_stream.sv
// Parallel-to-serial converter: LANES bits per beat, MSB/LSB-first per message,
// one-entry holding buffer for back-to-back messages, frame markers and flush.
module serialize_stream #(
   parameter int MSG_SIZE = 8,
   parameter int LANES    = 1
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iEn,
   input  logic                iFlush,
   input  logic                iLoad_Valid,
   input  logic                iMsb_First,
   input  logic [MSG_SIZE-1:0] iCiphertext,
   output logic                oLoad_Ready,
   output logic [LANES-1:0]    oData,
   output logic                oValid,
   output logic                oFirst,
   output logic                oLast,
   output logic                oDone_flag,
   output logic                oBusy
);

   localparam int BEATS = MSG_SIZE / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   if (MSG_SIZE % LANES != 0) begin : g_bad_lanes
      $error("serialize_stream: LANES must divide MSG_SIZE");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state, state_n;
   logic                  hb_full, hb_full_n;
   logic [MSG_SIZE-1:0]   hb_msg, hb_msg_n;
   logic                  hb_msb, hb_msb_n;
   logic [MSG_SIZE-1:0]   sr_msg, sr_msg_n;
   logic                  sr_msb, sr_msb_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [LANES-1:0]      data_q, data_n;
   logic                  valid_q, valid_n;
   logic                  first_q, first_n;
   logic                  last_q, last_n;
   logic                  last_evt, last_evt_n;
   logic                  done_q;

   logic                  present;
   logic [MSG_SIZE-1:0]   pick_msg;
   logic                  pick_msb;
   logic [CW-1:0]         pick_idx;

   function automatic logic [LANES-1:0] pick_beat(input logic [MSG_SIZE-1:0] msg,
                                                  input logic msb,
                                                  input logic [CW-1:0] idx);
      logic [MSG_SIZE-1:0] sh;
      if (msb)
         sh = msg >> (MSG_SIZE - (int'(idx) + 1) * LANES);
      else
         sh = msg >> (int'(idx) * LANES);
      return sh[LANES-1:0];
   endfunction

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state    <= IDLE;
         hb_full  <= 1'b0;
         hb_msg   <= '0;
         hb_msb   <= 1'b0;
         sr_msg   <= '0;
         sr_msb   <= 1'b0;
         cnt      <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         last_evt <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         hb_full  <= hb_full_n;
         hb_msg   <= hb_msg_n;
         hb_msb   <= hb_msb_n;
         sr_msg   <= sr_msg_n;
         sr_msb   <= sr_msb_n;
         cnt      <= cnt_n;
         data_q   <= data_n;
         valid_q  <= valid_n;
         first_q  <= first_n;
         last_q   <= last_n;
         last_evt <= last_evt_n;
         done_q   <= last_evt;
      end
   end

   // The buffer hands over whenever the shifter is free or finishing its last beat,
   // so back-to-back messages stream without a bubble.
   always_comb begin
      state_n    = state;
      hb_full_n  = hb_full;
      hb_msg_n   = hb_msg;
      hb_msb_n   = hb_msb;
      sr_msg_n   = sr_msg;
      sr_msb_n   = sr_msb;
      cnt_n      = cnt;
      data_n     = data_q;
      valid_n    = valid_q;
      first_n    = first_q;
      last_n     = last_q;
      last_evt_n = 1'b0;
      present    = 1'b0;
      pick_msg   = sr_msg;
      pick_msb   = sr_msb;
      pick_idx   = cnt;

      if (iFlush) begin
         state_n   = IDLE;
         hb_full_n = 1'b0;
         cnt_n     = '0;
         valid_n   = 1'b0;
         first_n   = 1'b0;
         last_n    = 1'b0;
      end else begin
         if (iLoad_Valid && !hb_full) begin
            hb_full_n = 1'b1;
            hb_msg_n  = iCiphertext;
            hb_msb_n  = iMsb_First;
         end
         if (iEn) begin
            if ((state == IDLE || cnt == LAST_BEAT) && hb_full) begin
               sr_msg_n  = hb_msg;
               sr_msb_n  = hb_msb;
               cnt_n     = '0;
               hb_full_n = 1'b0;
               state_n   = SHIFT;
               present   = 1'b1;
               pick_msg  = hb_msg;
               pick_msb  = hb_msb;
               pick_idx  = '0;
            end else if (state == SHIFT && cnt != LAST_BEAT) begin
               cnt_n    = cnt + 1'b1;
               present  = 1'b1;
               pick_idx = cnt + 1'b1;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
               valid_n = 1'b0;
               first_n = 1'b0;
               last_n  = 1'b0;
            end
         end
      end

      if (present) begin
         data_n     = pick_beat(pick_msg, pick_msb, pick_idx);
         valid_n    = 1'b1;
         first_n    = (pick_idx == '0);
         last_n     = (pick_idx == LAST_BEAT);
         last_evt_n = (pick_idx == LAST_BEAT);
      end
   end

   assign oLoad_Ready = !hb_full;
   assign oData       = data_q;
   assign oValid      = valid_q;
   assign oFirst      = first_q;
   assign oLast       = last_q;
   assign oDone_flag  = done_q;
   assign oBusy       = (state == SHIFT) || hb_full;

endmodule

// File: tb/tb_serialize_stream.sv
// Self-checking bench for serialize_stream: LANES=1 and LANES=2 instances,
// scoreboard queues of expected beats plus directed handshake/flush/reset steps.
module tb_serialize_stream;

   typedef struct packed {
      logic [1:0] data;
      logic       first;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       flush = 1'b0;
   logic       load_valid = 1'b0;
   logic       msb_first = 1'b0;
   logic [7:0] ct = '0;
   logic       ready, data, valid, first, last, done, busy;

   logic       b_load_valid = 1'b0;
   logic       b_msb = 1'b0;
   logic [7:0] b_ct = '0;
   logic       b_ready, b_valid, b_first, b_last, b_done, b_busy;
   logic [1:0] b_data;

   logic       en_at = 1'b0;
   logic       flush_at = 1'b0;
   logic       exp_done1 = 1'b0;
   logic       exp_done2 = 1'b0;
   beat_t      q1[$];
   beat_t      q2[$];
   beat_t      e1, e2;
   int         checks = 0;
   int         failures = 0;

   serialize_stream #(.MSG_SIZE(8), .LANES(1)) dut1 (
      .iClk(clk), .iRst(rst_n), .iEn(en), .iFlush(flush),
      .iLoad_Valid(load_valid), .iMsb_First(msb_first), .iCiphertext(ct),
      .oLoad_Ready(ready), .oData(data), .oValid(valid), .oFirst(first),
      .oLast(last), .oDone_flag(done), .oBusy(busy)
   );

   serialize_stream #(.MSG_SIZE(8), .LANES(2)) dut2 (
      .iClk(clk), .iRst(rst_n), .iEn(en), .iFlush(flush),
      .iLoad_Valid(b_load_valid), .iMsb_First(b_msb), .iCiphertext(b_ct),
      .oLoad_Ready(b_ready), .oData(b_data), .oValid(b_valid), .oFirst(b_first),
      .oLast(b_last), .oDone_flag(b_done), .oBusy(b_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_msg(input bit two, input logic [7:0] m, input logic msb);
      int    lanes;
      int    beats;
      beat_t e;
      lanes = two ? 2 : 1;
      beats = 8 / lanes;
      for (int i = 0; i < beats; i++) begin
         e.data = 2'b00;
         for (int j = 0; j < lanes; j++)
            e.data[j] = msb ? m[8 - (i + 1) * lanes + j] : m[i * lanes + j];
         e.first = (i == 0);
         e.last  = (i == beats - 1);
         if (two) q2.push_back(e);
         else     q1.push_back(e);
      end
   endtask

   task automatic applyStimulus(input bit two, input logic [7:0] m, input logic msb);
      int t = 0;
      while ((two ? !b_ready : !ready) && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      if (two) check("ready2_wait", b_ready, 1);
      else     check("ready1_wait", ready, 1);
      if (two) begin
         b_load_valid = 1'b1; b_ct = m; b_msb = msb;
      end else begin
         load_valid = 1'b1; ct = m; msb_first = msb;
      end
      push_msg(two, m, msb);
      @(posedge clk); #2;
      load_valid   = 1'b0;
      b_load_valid = 1'b0;
   endtask

   task automatic waitIdle(input bit two);
      int t = 0;
      do begin
         @(posedge clk); #2;
         t++;
      end while ((two ? (b_busy || b_valid) : (busy || valid)) && t < 200);
      if (two) check("idle2_wait", b_busy, 0);
      else     check("idle1_wait", busy, 0);
      @(posedge clk); #2;
   endtask

   task automatic checkOutput(input string tag, input logic exp_ready, input logic exp_busy);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_data"},  data, 0);
      check({tag, "_first"}, first, 0);
      check({tag, "_last"},  last, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_ready"}, ready, exp_ready);
      check({tag, "_busy"},  busy, exp_busy);
   endtask

   always @(posedge clk) begin
      en_at    <= en;
      flush_at <= flush;
   end

   // A beat is new only if the edge that produced it had iEn high and no flush.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_done1 = 1'b0;
      end else begin
         check("done1", done, exp_done1);
         exp_done1 = 1'b0;
         if (en_at && !flush_at && valid) begin
            check("beat1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
               e1 = q1.pop_front();
               check("beat1", {1'b0, data, first, last}, e1);
               exp_done1 = e1.last;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_done2 = 1'b0;
      end else begin
         check("done2", b_done, exp_done2);
         exp_done2 = 1'b0;
         if (en_at && !flush_at && b_valid) begin
            check("beat2_expected", q2.size() != 0, 1);
            if (q2.size() != 0) begin
               e2 = q2.pop_front();
               check("beat2", {b_data, b_first, b_last}, e2);
               exp_done2 = e2.last;
            end
         end
      end
   end

   initial begin
      logic [7:0] msg;

      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset", 1, 0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      applyStimulus(0, 8'hB4, 0);
      check("lat_valid_k", valid, 0);
      check("lat_ready_k", ready, 0);
      check("lat_busy_k", busy, 1);
      @(posedge clk); #2;
      check("lat_valid_k1", valid, 1);
      check("lat_first_k1", first, 1);
      check("lat_ready_k1", ready, 1);
      waitIdle(0);

      applyStimulus(0, 8'hB4, 1);
      waitIdle(0);

      applyStimulus(1, 8'hB4, 0);
      waitIdle(1);
      applyStimulus(1, 8'hB4, 1);
      waitIdle(1);

      applyStimulus(0, 8'hB4, 0);
      applyStimulus(0, 8'h3C, 0);
      for (int i = 2; i <= 16; i++) begin
         check("b2b_valid", valid, 1);
         check("b2b_ready", ready, (i >= 9));
         check("b2b_first", first, (i == 9));
         @(posedge clk); #2;
      end
      check("b2b_end_valid", valid, 0);
      waitIdle(0);

      msg = 8'h5A;
      applyStimulus(0, msg, 1);
      repeat (3) begin
         @(posedge clk); #2;
      end
      en = 1'b0;
      repeat (2) begin
         @(posedge clk); #2;
         check("stall_valid", valid, 1);
         check("stall_data", data, msg[5]);
         check("stall_first", first, 0);
      end
      en = 1'b1;
      waitIdle(0);

      applyStimulus(0, 8'hB4, 0);
      applyStimulus(0, 8'h3C, 0);
      repeat (2) begin
         @(posedge clk); #2;
      end
      check("preflush_busy", busy, 1);
      check("preflush_ready", ready, 0);
      flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
      q1.delete();
      check("flush_valid", valid, 0);
      check("flush_ready", ready, 1);
      check("flush_busy", busy, 0);
      check("flush_done", done, 0);
      repeat (3) begin
         @(posedge clk); #2;
      end
      check("postflush_valid", valid, 0);

      applyStimulus(0, 8'hB4, 1);
      repeat (3) begin
         @(posedge clk); #2;
      end
      check("prereset_valid", valid, 1);
      #1 rst_n = 1'b0;
      #1;
      q1.delete();
      checkOutput("async_reset", 1, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #2;
      end
      check("postreset_valid", valid, 0);
      check("q1_empty", q1.size(), 0);
      check("q2_empty", q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
